// File: rtl/proc_pkg.sv
// Shared definitions for the program sequencer: word width, opcode field
// position and values, and the sequencer state encoding.
package proc_pkg;

  localparam int PKG_DW  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;

  localparam logic [2:0] MVI_OP_DEF  = 3'b001;
  localparam logic [2:0] HALT_OP_DEF = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_HALT,
    ST_ERROR
  } seq_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: DEPTH x DW words, synchronous write, asynchronous read.
module prog_mem
  import proc_pkg::*;
#(
  parameter int DW = PKG_DW,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Write port; contents are loaded by the host before execution.
  // NOTE: the array has no reset branch so it maps onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: feeds instruction / immediate words to the processor,
// pulses run and waits for done, with halt detection, a done watchdog and a
// saturating instruction counter.
// Optional feature: define SINGLE_STEP_EN to add a `step` input; each FETCH
// then waits for a step pulse before reading the next instruction.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int         DW      = PKG_DW,
  parameter int         AW      = 5,
  parameter int         TIMEOUT = 64,
  parameter logic [2:0] MVI_OP  = MVI_OP_DEF,
  parameter logic [2:0] HALT_OP = HALT_OP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          done,
`ifdef SINGLE_STEP_EN
  input  logic          step,
`endif
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] din,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [15:0]   instr_cnt
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [DW-1:0] r_din;
  logic [AW-1:0] r_pc;
  logic          r_halted;
  logic          r_err;
  logic [15:0]   r_instr_cnt;
  logic [WDW-1:0] r_wdog;
  logic          r_is_mvi;

  logic [AW-1:0] w_raddr;
  logic [DW-1:0] w_rdata;
  logic          w_busy;
  logic          w_step_ok;
  logic          w_rd_is_halt;
  logic          w_din_is_mvi;
  logic          w_timeout;

`ifdef SINGLE_STEP_EN
  assign w_step_ok = step;
`else
  assign w_step_ok = 1'b1;
`endif

  assign w_busy       = (r_state == ST_FETCH) || (r_state == ST_ISSUE) ||
                        (r_state == ST_WAIT_DONE);
  // ISSUE reads the immediate slot; every other state reads the current pc.
  assign w_raddr      = (r_state == ST_ISSUE) ? r_pc + AW'(1) : r_pc;
  assign w_rd_is_halt = (w_rdata[OPC_MSB:OPC_LSB] == HALT_OP);
  assign w_din_is_mvi = (r_din[OPC_MSB:OPC_LSB] == MVI_OP);
  assign w_timeout    = (r_wdog == WDW'(TIMEOUT - 1));

  prog_mem #(
    .DW (DW),
    .AW (AW)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (prog_we && !w_busy),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // State register.
  // NOTE: clocked blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_step_ok) w_state_nxt = w_rd_is_halt ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done)           w_state_nxt = ST_FETCH;
        else if (w_timeout) w_state_nxt = ST_ERROR;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: instruction word, pc, status flags, watchdog and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_din       <= '0;
      r_pc        <= '0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
      r_instr_cnt <= '0;
      r_wdog      <= '0;
      r_is_mvi    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT, ST_ERROR: begin
          if (start) begin
            r_pc        <= '0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
            r_instr_cnt <= '0;
          end
        end
        ST_FETCH: begin
          if (w_step_ok) begin
            r_din <= w_rdata;
            if (w_rd_is_halt) r_halted <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_wdog   <= '0;
          r_is_mvi <= w_din_is_mvi;
          if (w_din_is_mvi) r_din <= w_rdata;
        end
        ST_WAIT_DONE: begin
          r_wdog <= r_wdog + WDW'(1);
          if (done) begin
            r_pc <= r_pc + (r_is_mvi ? AW'(2) : AW'(1));
            if (r_instr_cnt != 16'hFFFF) r_instr_cnt <= r_instr_cnt + 16'd1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign din       = r_din;
  assign run       = (r_state == ST_ISSUE);
  assign pc        = r_pc;
  assign busy      = w_busy;
  assign halted    = r_halted;
  assign err       = r_err;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer (default build, no single-step).
module tb_prog_sequencer;

  localparam int DW         = 16;
  localparam int AW         = 5;
  localparam int TIMEOUT    = 64;
  localparam int RUN_BUDGET = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [DW-1:0] din;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          err;
  logic [15:0]   instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  prog_sequencer #(
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .din       (din),
    .run       (run),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step_cycle();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step_cycle();
    done = 1'b0;
  endtask

  // Bounded wait until run is high in the current sampled cycle.
  task automatic wait_run(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < RUN_BUDGET) begin
      if (run === 1'b1) ok = 1'b1;
      else begin
        step_cycle();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; done = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    step_cycle(); step_cycle();
    n_tests++;
    if ({din, run, pc, busy, halted, err, instr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: din=%h run=%b pc=%0d busy=%b halted=%b err=%b cnt=%0d, want all zero",
               din, run, pc, busy, halted, err, instr_cnt);
    end
    reset = 1'b0;
    pulse_done();
    n_tests++;
    if (busy !== 1'b0 || instr_cnt !== 16'd0 || run !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_idle: busy=%b cnt=%0d run=%b, want 0/0/0", busy, instr_cnt, run);
    end
  endtask

  task automatic test_basic();
    bit ok;
    load_word(5'd0, 16'h0040);
    load_word(5'd1, 16'h0080);
    load_word(5'd2, 16'hE000);
    pulse_start();
    n_tests++;
    if (run !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_cycle: run=%b busy=%b, want run=0 busy=1", run, busy);
    end
    step_cycle();
    n_tests++;
    if (run !== 1'b1 || din !== 16'h0040 || pc !== 5'd0) begin
      n_fail++;
      $display("FAIL first_run: run=%b din=%h pc=%0d, want 1/0040/0", run, din, pc);
    end
    step_cycle();
    n_tests++;
    if (run !== 1'b0) begin
      n_fail++;
      $display("FAIL run_one_cycle: run=%b, want 0", run);
    end
    step_cycle(); step_cycle();
    pulse_done();
    n_tests++;
    if (run !== 1'b0 || pc !== 5'd1) begin
      n_fail++;
      $display("FAIL after_done_fetch: run=%b pc=%0d, want 0/1", run, pc);
    end
    step_cycle();
    n_tests++;
    if (run !== 1'b1 || din !== 16'h0080) begin
      n_fail++;
      $display("FAIL second_run: run=%b din=%h, want 1/0080", run, din);
    end
    step_cycle(); step_cycle(); step_cycle();
    pulse_done();
    step_cycle();
    wait_run(ok);
    n_tests++;
    if (ok || halted !== 1'b1 || pc !== 5'd2 || instr_cnt !== 16'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_basic: extra_run=%b halted=%b pc=%0d cnt=%0d busy=%b, want 0/1/2/2/0",
               ok, halted, pc, instr_cnt, busy);
    end
  endtask

  task automatic test_mvi();
    load_word(5'd0, 16'h2000);
    load_word(5'd1, 16'h1234);
    load_word(5'd2, 16'hE000);
    pulse_start();
    step_cycle();
    n_tests++;
    if (run !== 1'b1 || din !== 16'h2000) begin
      n_fail++;
      $display("FAIL mvi_run: run=%b din=%h, want 1/2000", run, din);
    end
    step_cycle();
    n_tests++;
    if (run !== 1'b0 || din !== 16'h1234) begin
      n_fail++;
      $display("FAIL mvi_imm: run=%b din=%h, want 0/1234", run, din);
    end
    step_cycle();
    n_tests++;
    if (din !== 16'h1234) begin
      n_fail++;
      $display("FAIL mvi_imm_hold: din=%h, want 1234", din);
    end
    pulse_done();
    step_cycle();
    n_tests++;
    if (pc !== 5'd2 || halted !== 1'b1 || instr_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mvi_halt: pc=%0d halted=%b cnt=%0d, want 2/1/1", pc, halted, instr_cnt);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int run_seen;
    run_seen = 0;
    load_word(5'd0, 16'h0040);
    pulse_start();
    wait_run(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wdog_run: run=%b, want 1 within %0d cycles", run, RUN_BUDGET);
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      step_cycle();
      if (run === 1'b1) run_seen++;
    end
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_early: err=%b busy=%b, want 0/1", err, busy);
    end
    step_cycle();
    if (run === 1'b1) run_seen++;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || pc !== 5'd0 || run_seen != 0) begin
      n_fail++;
      $display("FAIL wdog_expire: err=%b busy=%b pc=%0d runs=%0d, want 1/0/0/0",
               err, busy, pc, run_seen);
    end
  endtask

  task automatic test_prog_write();
    bit ok;
    load_word(5'd0, 16'h0040);
    load_word(5'd1, 16'h0080);
    load_word(5'd2, 16'hE000);
    pulse_start();
    wait_run(ok);
    step_cycle();
    load_word(5'd1, 16'hFFFF);
    pulse_done();
    wait_run(ok);
    n_tests++;
    if (!ok || din !== 16'h0080) begin
      n_fail++;
      $display("FAIL write_while_busy: run=%b din=%h, want 1/0080", ok, din);
    end
    step_cycle();
    pulse_done();
    step_cycle();
    n_tests++;
    if (halted !== 1'b1 || pc !== 5'd2) begin
      n_fail++;
      $display("FAIL write_busy_halt: halted=%b pc=%0d, want 1/2", halted, pc);
    end
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hFFFF; start = 1'b1;
    step_cycle();
    prog_we = 1'b0; start = 1'b0;
    wait_run(ok);
    n_tests++;
    if (!ok || din !== 16'h0040) begin
      n_fail++;
      $display("FAIL write_start_run: run=%b din=%h, want 1/0040", ok, din);
    end
    step_cycle();
    pulse_done();
    step_cycle();
    n_tests++;
    if (halted !== 1'b1 || pc !== 5'd1 || din !== 16'hFFFF || instr_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL write_idle_applied: halted=%b pc=%0d din=%h cnt=%0d, want 1/1/FFFF/1",
               halted, pc, din, instr_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int bad;
    logic [DW-1:0] exp_w;
    bad = 0;
    load_word(5'd0, 16'h0C5A);
    for (int i = 1; i < 31; i++) load_word(AW'(i), 16'h0100 + 16'(i));
    load_word(5'd31, 16'h2000);
    pulse_start();
    for (int i = 0; i < 31; i++) begin
      exp_w = (i == 0) ? 16'h0C5A : 16'h0100 + 16'(i);
      wait_run(ok);
      if (!ok || din !== exp_w || pc !== AW'(i)) bad++;
      step_cycle();
      pulse_done();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_sequence: %0d bad instructions, want 0", bad);
    end
    wait_run(ok);
    n_tests++;
    if (!ok || din !== 16'h2000 || pc !== 5'd31) begin
      n_fail++;
      $display("FAIL wrap_mvi_run: run=%b din=%h pc=%0d, want 1/2000/31", ok, din, pc);
    end
    step_cycle();
    n_tests++;
    if (din !== 16'h0C5A) begin
      n_fail++;
      $display("FAIL wrap_imm: din=%h, want 0C5A", din);
    end
    pulse_done();
    n_tests++;
    if (pc !== 5'd1 || instr_cnt !== 16'd32) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%0d cnt=%0d, want 1/32", pc, instr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_run(ok);
    step_cycle();
    n_tests++;
    if (busy !== 1'b1 || din !== 16'h0101) begin
      n_fail++;
      $display("FAIL pre_reset_wait: busy=%b din=%h, want 1/0101", busy, din);
    end
    reset = 1'b1;
    step_cycle();
    n_tests++;
    if (run !== 1'b0 || busy !== 1'b0 || pc !== 5'd0 || instr_cnt !== 16'd0 || din !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: run=%b busy=%b pc=%0d cnt=%0d din=%h, want 0/0/0/0/0000",
               run, busy, pc, instr_cnt, din);
    end
    reset = 1'b0;
    load_word(5'd2, 16'hE000);
    pulse_start();
    wait_run(ok);
    n_tests++;
    if (!ok || din !== 16'h0C5A) begin
      n_fail++;
      $display("FAIL rerun_first: run=%b din=%h, want 1/0C5A", ok, din);
    end
    step_cycle();
    pulse_done();
    wait_run(ok);
    n_tests++;
    if (!ok || din !== 16'h0101) begin
      n_fail++;
      $display("FAIL rerun_second: run=%b din=%h, want 1/0101", ok, din);
    end
    step_cycle();
    pulse_done();
    step_cycle();
    n_tests++;
    if (halted !== 1'b1 || pc !== 5'd2 || instr_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL rerun_halt: halted=%b pc=%0d cnt=%0d, want 1/2/2", halted, pc, instr_cnt);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_mvi();
    test_watchdog();
    test_prog_write();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
